// File: rtl/alu_muldiv_if.sv
// rtl/alu_muldiv_if.sv - start/busy/done handshake and operand/result bundle for alu_muldiv
interface alu_muldiv_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] op_hi;
  logic [WIDTH-1:0] op_lo;
  logic [WIDTH-1:0] op2;
  logic [11:0]      flags;
  logic             busy;
  logic             done;
  logic             fault;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic [11:0]      flags_o;

  modport master (
    output start, mode, op_hi, op_lo, op2, flags,
    input  busy, done, fault, res_hi, res_lo, flags_o
  );

  modport slave (
    input  start, mode, op_hi, op_lo, op2, flags,
    output busy, done, fault, res_hi, res_lo, flags_o
  );
endinterface

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - sequential MUL/IMUL/DIV/IDIV unit with 8086-style flags and divide fault
module alu_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  alu_muldiv_if.slave  bus
);

  localparam int         CW     = $clog2(WIDTH) + 1;
  localparam logic [1:0] M_IDIV = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH:0]   acc_q, acc_d;      // product high / partial remainder (extra bit holds carry)
  logic [WIDTH-1:0] ql_q, ql_d;        // multiplier-product low / dividend-quotient low
  logic [WIDTH-1:0] b_q, b_d;          // multiplicand / divisor magnitude
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             pfault_q, pfault_d;
  logic [11:0]      flags_in_q, flags_in_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [11:0]      flags_o_q, flags_o_d;

  logic [2*WIDTH-1:0] dvd, mag_dvd, prod, prod_fin;
  logic [WIDTH-1:0]   mag_b, q_fin, r_fin;
  logic [WIDTH:0]     sh, sum;
  logic               neg_a, neg_b, ge, ovf, cflag;
  logic [11:0]        f_new;

  // Next-state and datapath: operand latch, sign stripping, iterate, sign fix-up, commit
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    acc_d      = acc_q;
    ql_d       = ql_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    pfault_d   = pfault_q;
    flags_in_d = flags_in_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    fault_d    = 1'b0;
    res_hi_d   = res_hi_q;
    res_lo_d   = res_lo_q;
    flags_o_d  = flags_o_q;
    dvd        = '0;
    mag_dvd    = '0;
    prod       = '0;
    prod_fin   = '0;
    mag_b      = '0;
    q_fin      = '0;
    r_fin      = '0;
    sh         = '0;
    sum        = '0;
    neg_a      = 1'b0;
    neg_b      = 1'b0;
    ge         = 1'b0;
    ovf        = 1'b0;
    cflag      = 1'b0;
    f_new      = flags_in_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mode_d     = bus.mode;
          acc_d      = {1'b0, bus.op_hi};
          ql_d       = bus.op_lo;
          b_d        = bus.op2;
          flags_in_d = bus.flags;
          busy_d     = 1'b1;
          state_d    = S_PREP;
        end
      end

      S_PREP: begin
        neg_b = mode_q[0] & b_q[WIDTH-1];
        mag_b = neg_b ? -b_q : b_q;
        if (mode_q[1]) begin
          dvd      = {acc_q[WIDTH-1:0], ql_q};
          neg_a    = mode_q[0] & acc_q[WIDTH-1];
          mag_dvd  = neg_a ? -dvd : dvd;
          acc_d    = {1'b0, mag_dvd[2*WIDTH-1:WIDTH]};
          ql_d     = mag_dvd[WIDTH-1:0];
          rneg_d   = neg_a;
          // A high half not below the divisor means the quotient cannot fit in WIDTH bits
          pfault_d = (b_q == '0) | (mag_dvd[2*WIDTH-1:WIDTH] >= mag_b);
        end else begin
          neg_a    = mode_q[0] & ql_q[WIDTH-1];
          acc_d    = '0;
          ql_d     = neg_a ? -ql_q : ql_q;
          rneg_d   = 1'b0;
          pfault_d = 1'b0;
        end
        qneg_d  = neg_a ^ neg_b;
        b_d     = mag_b;
        cnt_d   = CW'(WIDTH - 1);
        state_d = S_RUN;
      end

      S_RUN: begin
        if (mode_q[1]) begin
          sh    = {acc_q[WIDTH-1:0], ql_q[WIDTH-1]};
          ge    = (sh >= {1'b0, b_q});
          acc_d = ge ? (sh - {1'b0, b_q}) : sh;
          ql_d  = {ql_q[WIDTH-2:0], ge};
        end else begin
          sum   = acc_q + {1'b0, (ql_q[0] ? b_q : {WIDTH{1'b0}})};
          acc_d = {1'b0, sum[WIDTH:1]};
          ql_d  = {sum[0], ql_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_FIX: begin
        prod     = {acc_q[WIDTH-1:0], ql_q};
        prod_fin = qneg_q ? -prod : prod;
        q_fin    = qneg_q ? -ql_q : ql_q;
        r_fin    = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        // Quotient magnitude with the top bit set is out of signed range, including -2^(WIDTH-1)
        ovf      = pfault_q | ((mode_q == M_IDIV) & ql_q[WIDTH-1]);
        f_new[1] = 1'b1;
        f_new[3] = 1'b0;
        f_new[5] = 1'b0;
        if (!mode_q[1]) begin
          cflag     = mode_q[0] ? (prod_fin[2*WIDTH-1:WIDTH] != {WIDTH{prod_fin[WIDTH-1]}})
                                : (prod_fin[2*WIDTH-1:WIDTH] != '0);
          f_new[0]  = cflag;
          f_new[11] = cflag;
        end
        if (!ovf) begin
          res_hi_d  = mode_q[1] ? r_fin : prod_fin[2*WIDTH-1:WIDTH];
          res_lo_d  = mode_q[1] ? q_fin : prod_fin[WIDTH-1:0];
          flags_o_d = f_new;
        end
        fault_d = ovf;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any operation in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      acc_q      <= '0;
      ql_q       <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      pfault_q   <= 1'b0;
      flags_in_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      res_hi_q   <= '0;
      res_lo_q   <= '0;
      flags_o_q  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      acc_q      <= acc_d;
      ql_q       <= ql_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      pfault_q   <= pfault_d;
      flags_in_q <= flags_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
      res_hi_q   <= res_hi_d;
      res_lo_q   <= res_lo_d;
      flags_o_q  <= flags_o_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.fault   = fault_q;
  assign bus.res_hi  = res_hi_q;
  assign bus.res_lo  = res_lo_q;
  assign bus.flags_o = flags_o_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - directed-vector bench for alu_muldiv at WIDTH 8, 16 and 32
module tb_alu_muldiv;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  alu_muldiv_if #(.WIDTH(8))  if8 ();
  alu_muldiv_if #(.WIDTH(16)) if16 ();
  alu_muldiv_if #(.WIDTH(32)) if32 ();

  logic [2:0]  t_start;
  logic [1:0]  t_mode;
  logic [31:0] t_hi, t_lo, t_b;
  logic [11:0] t_flags;
  int          sel;

  assign if8.start  = t_start[0];
  assign if8.mode   = t_mode;
  assign if8.op_hi  = t_hi[7:0];
  assign if8.op_lo  = t_lo[7:0];
  assign if8.op2    = t_b[7:0];
  assign if8.flags  = t_flags;
  assign if16.start = t_start[1];
  assign if16.mode  = t_mode;
  assign if16.op_hi = t_hi[15:0];
  assign if16.op_lo = t_lo[15:0];
  assign if16.op2   = t_b[15:0];
  assign if16.flags = t_flags;
  assign if32.start = t_start[2];
  assign if32.mode  = t_mode;
  assign if32.op_hi = t_hi;
  assign if32.op_lo = t_lo;
  assign if32.op2   = t_b;
  assign if32.flags = t_flags;

  alu_muldiv #(.WIDTH(8))  u_dut8  (.clock(clock), .reset(reset), .bus(if8.slave));
  alu_muldiv #(.WIDTH(16)) u_dut16 (.clock(clock), .reset(reset), .bus(if16.slave));
  alu_muldiv #(.WIDTH(32)) u_dut32 (.clock(clock), .reset(reset), .bus(if32.slave));

  logic        obs_busy, obs_done, obs_fault;
  logic [31:0] obs_hi, obs_lo;
  logic [11:0] obs_flags;

  always_comb begin
    obs_busy  = if16.busy;
    obs_done  = if16.done;
    obs_fault = if16.fault;
    obs_hi    = {16'h0, if16.res_hi};
    obs_lo    = {16'h0, if16.res_lo};
    obs_flags = if16.flags_o;
    case (sel)
      8: begin
        obs_busy  = if8.busy;
        obs_done  = if8.done;
        obs_fault = if8.fault;
        obs_hi    = {24'h0, if8.res_hi};
        obs_lo    = {24'h0, if8.res_lo};
        obs_flags = if8.flags_o;
      end
      32: begin
        obs_busy  = if32.busy;
        obs_done  = if32.done;
        obs_fault = if32.fault;
        obs_hi    = if32.res_hi;
        obs_lo    = if32.res_lo;
        obs_flags = if32.flags_o;
      end
      default: ;
    endcase
  end

  int   errors = 0;
  int   checks = 0;
  int   cyc, bcyc;
  logic got_done;

  // Starts one operation on the selected width and waits (bounded) for done
  task automatic op(input int w, input logic [1:0] m, input logic [31:0] hi, input logic [31:0] lo,
                    input logic [31:0] b, input logic [11:0] f);
    sel = w;
    @(posedge clock); #1;
    t_mode = m; t_hi = hi; t_lo = lo; t_b = b; t_flags = f;
    t_start = (w == 8) ? 3'b001 : (w == 32) ? 3'b100 : 3'b010;
    cyc = 0; bcyc = 0; got_done = 1'b0;
    for (int k = 1; k <= 80 && !got_done; k++) begin
      @(posedge clock); #1;
      t_start = 3'b000;
      if (obs_busy) bcyc++;
      if (obs_done) begin got_done = 1'b1; cyc = k; end
    end
    checks++;
    if (!got_done) begin errors++; $display("FAIL op_timeout w=%0d mode=%0d: done not seen, required within 80 cycles", w, m); end
  endtask

  task automatic test_reset();
    #2;
    for (int w = 8; w <= 32; w = w * 2) begin
      sel = w; #1;
      checks++;
      if (obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_fault !== 1'b0 || obs_hi !== 32'h0 || obs_lo !== 32'h0 || obs_flags !== 12'h0) begin
        errors++;
        $display("FAIL reset_state w=%0d: busy=%b done=%b fault=%b hi=%h lo=%h flags=%h, required all 0", w, obs_busy, obs_done, obs_fault, obs_hi, obs_lo, obs_flags);
      end
    end
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_mul();
    op(16, 2'd0, 32'h0, 32'hFFFF, 32'hFFFF, 12'h7D4);
    checks++; if (cyc !== 19) begin errors++; $display("FAIL mul_latency: got %0d cycles, required 19", cyc); end
    checks++; if (bcyc !== 18) begin errors++; $display("FAIL mul_busy_len: got %0d cycles, required 18", bcyc); end
    checks++; if (obs_hi !== 32'hFFFE || obs_lo !== 32'h0001) begin errors++; $display("FAIL mul_ffff: got %h:%h, required 0000fffe:00000001", obs_hi, obs_lo); end
    checks++; if (obs_flags !== 12'hFD7 || obs_fault !== 1'b0) begin errors++; $display("FAIL mul_flags: got flags=%h fault=%b, required fd7 0", obs_flags, obs_fault); end
  endtask

  task automatic test_imul();
    op(16, 2'd1, 32'h0, 32'hFFFF, 32'h0002, 12'hFFF);
    checks++; if (obs_hi !== 32'hFFFF || obs_lo !== 32'hFFFE) begin errors++; $display("FAIL imul_neg: got %h:%h, required 0000ffff:0000fffe", obs_hi, obs_lo); end
    checks++; if (obs_flags !== 12'h7D6) begin errors++; $display("FAIL imul_neg_flags: got %h, required 7d6", obs_flags); end
    op(16, 2'd1, 32'h0, 32'h4000, 32'h0002, 12'h000);
    checks++; if (obs_hi !== 32'h0000 || obs_lo !== 32'h8000) begin errors++; $display("FAIL imul_ovf: got %h:%h, required 00000000:00008000", obs_hi, obs_lo); end
    checks++; if (obs_flags !== 12'h803) begin errors++; $display("FAIL imul_ovf_flags: got %h, required 803", obs_flags); end
  endtask

  task automatic test_div();
    op(16, 2'd2, 32'h0001, 32'h0000, 32'h0003, 12'h801);
    checks++; if (obs_lo !== 32'h5555 || obs_hi !== 32'h0001) begin errors++; $display("FAIL div_basic: got q=%h r=%h, required q=00005555 r=00000001", obs_lo, obs_hi); end
    checks++; if (obs_flags !== 12'h803 || obs_fault !== 1'b0) begin errors++; $display("FAIL div_flags: got flags=%h fault=%b, required 803 0", obs_flags, obs_fault); end
    op(16, 2'd3, 32'hFFFF, 32'hFFFA, 32'h0003, 12'h000);
    checks++; if (obs_lo !== 32'hFFFE || obs_hi !== 32'h0000) begin errors++; $display("FAIL idiv_exact: got q=%h r=%h, required q=0000fffe r=00000000", obs_lo, obs_hi); end
    op(16, 2'd3, 32'hFFFF, 32'hFFF9, 32'h0002, 12'h028);
    checks++; if (obs_lo !== 32'hFFFD || obs_hi !== 32'hFFFF) begin errors++; $display("FAIL idiv_neg: got q=%h r=%h, required q=0000fffd r=0000ffff", obs_lo, obs_hi); end
    checks++; if (obs_flags !== 12'h002) begin errors++; $display("FAIL idiv_flags: got %h, required 002", obs_flags); end
  endtask

  task automatic test_faults();
    op(16, 2'd2, 32'h1234, 32'h5678, 32'h0000, 12'hFFF);
    checks++; if (obs_fault !== 1'b1) begin errors++; $display("FAIL fault_div0: got fault=%b, required 1", obs_fault); end
    checks++; if (obs_lo !== 32'hFFFD || obs_hi !== 32'hFFFF || obs_flags !== 12'h002) begin errors++; $display("FAIL fault_div0_hold: got %h:%h flags=%h, required 0000ffff:0000fffd 002", obs_hi, obs_lo, obs_flags); end
    op(16, 2'd2, 32'h0002, 32'h0000, 32'h0002, 12'hFFF);
    checks++; if (obs_fault !== 1'b1) begin errors++; $display("FAIL fault_div_ovf: got fault=%b, required 1", obs_fault); end
    checks++; if (obs_lo !== 32'hFFFD || obs_hi !== 32'hFFFF || obs_flags !== 12'h002) begin errors++; $display("FAIL fault_div_ovf_hold: got %h:%h flags=%h, required 0000ffff:0000fffd 002", obs_hi, obs_lo, obs_flags); end
    op(16, 2'd3, 32'hFFFF, 32'h8000, 32'h0001, 12'hFFF);
    checks++; if (obs_fault !== 1'b1) begin errors++; $display("FAIL fault_idiv_min: got fault=%b, required 1", obs_fault); end
    checks++; if (obs_lo !== 32'hFFFD || obs_hi !== 32'hFFFF || obs_flags !== 12'h002) begin errors++; $display("FAIL fault_idiv_min_hold: got %h:%h flags=%h, required 0000ffff:0000fffd 002", obs_hi, obs_lo, obs_flags); end
  endtask

  task automatic test_back_to_back();
    op(16, 2'd0, 32'h0, 32'h0007, 32'h0009, 12'h000);
    checks++; if (obs_lo !== 32'h003F || obs_hi !== 32'h0 || obs_flags !== 12'h002 || obs_fault !== 1'b0) begin errors++; $display("FAIL b2b_first: got %h:%h flags=%h fault=%b, required 0:3f 002 0", obs_hi, obs_lo, obs_flags, obs_fault); end
    op(16, 2'd0, 32'h0, 32'h0100, 32'h0100, 12'h000);
    checks++; if (cyc !== 19) begin errors++; $display("FAIL b2b_latency: got %0d cycles, required 19", cyc); end
    checks++; if (obs_hi !== 32'h0001 || obs_lo !== 32'h0000) begin errors++; $display("FAIL b2b_second: got %h:%h, required 00000001:00000000", obs_hi, obs_lo); end
  endtask

  task automatic test_busy_ignore();
    int ndone = 0;
    int first = 0;
    logic [31:0] lo_seen = 32'h0;
    sel = 16;
    @(posedge clock); #1;
    t_mode = 2'd0; t_hi = 32'h0; t_lo = 32'h0002; t_b = 32'h0003; t_flags = 12'h000; t_start = 3'b010;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clock); #1;
      if (k == 1) t_start = 3'b000;
      if (k == 3) begin t_start = 3'b010; t_lo = 32'h0011; t_b = 32'h0011; end
      if (k == 4) t_start = 3'b000;
      if (obs_done) begin
        ndone++;
        if (first == 0) begin first = k; lo_seen = obs_lo; end
      end
    end
    checks++; if (first !== 19 || ndone !== 1) begin errors++; $display("FAIL busy_ignore_done: first at %0d count %0d, required 19 and 1", first, ndone); end
    checks++; if (lo_seen !== 32'h0006) begin errors++; $display("FAIL busy_ignore_result: got %h, required 00000006", lo_seen); end
  endtask

  task automatic test_reset_mid_op();
    int seen = 0;
    sel = 16;
    @(posedge clock); #1;
    t_mode = 2'd2; t_hi = 32'h0001; t_lo = 32'h0000; t_b = 32'h0003; t_flags = 12'hFFF; t_start = 3'b010;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clock); #1;
      t_start = 3'b000;
    end
    reset = 1'b1; #1;
    checks++;
    if (obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_fault !== 1'b0 || obs_hi !== 32'h0 || obs_lo !== 32'h0 || obs_flags !== 12'h0) begin
      errors++;
      $display("FAIL reset_mid_op: busy=%b done=%b fault=%b hi=%h lo=%h flags=%h, required all 0", obs_busy, obs_done, obs_fault, obs_hi, obs_lo, obs_flags);
    end
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clock); #1;
      if (obs_done) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL reset_no_done: got %0d done pulses, required 0", seen); end
    op(16, 2'd0, 32'h0, 32'h0003, 32'h0005, 12'h000);
    checks++; if (cyc !== 19 || obs_lo !== 32'h000F || obs_hi !== 32'h0) begin errors++; $display("FAIL reset_restart: got %0d cycles %h:%h, required 19 0:f", cyc, obs_hi, obs_lo); end
  endtask

  task automatic test_width8();
    op(8, 2'd0, 32'h0, 32'h00FF, 32'h00FF, 12'h000);
    checks++; if (cyc !== 11) begin errors++; $display("FAIL w8_latency: got %0d cycles, required 11", cyc); end
    checks++; if (obs_hi !== 32'hFE || obs_lo !== 32'h01 || obs_flags !== 12'h803) begin errors++; $display("FAIL w8_mul: got %h:%h flags=%h, required fe:01 803", obs_hi, obs_lo, obs_flags); end
  endtask

  task automatic test_width32();
    op(32, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h00000002, 12'h002);
    checks++; if (cyc !== 35) begin errors++; $display("FAIL w32_latency: got %0d cycles, required 35", cyc); end
    checks++; if (obs_lo !== 32'hFFFFFFFD || obs_hi !== 32'hFFFFFFFF || obs_fault !== 1'b0) begin errors++; $display("FAIL w32_idiv: got q=%h r=%h fault=%b, required q=fffffffd r=ffffffff 0", obs_lo, obs_hi, obs_fault); end
  endtask

  initial begin
    t_start = 3'b000; t_mode = 2'd0; t_hi = 32'h0; t_lo = 32'h0; t_b = 32'h0; t_flags = 12'h0; sel = 16;
    test_reset();
    test_mul();
    test_imul();
    test_div();
    test_faults();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_op();
    test_width8();
    test_width32();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
